// File: rtl/mirrored_ram.sv
// mirrored_ram: CPU-bus work RAM with base/mask window decode.
// A 2^DEPTH_LOG2-word array is mirrored across the decode window by ignoring
// address bits above the index. After reset an optional sequencer fills the
// array with FILL_VALUE (busy high). Reads are registered with a one-cycle
// rdata_valid strobe. cpu_rdata doubles as the open-bus latch and tracks the
// last byte transferred on the bus.
module mirrored_ram #(
    parameter int                  DATA_W         = 8,
    parameter int                  ADDR_W         = 16,
    parameter int                  DEPTH_LOG2     = 11,
    parameter logic [ADDR_W-1:0]   BASE_ADDR      = 16'h0000,
    parameter logic [ADDR_W-1:0]   DECODE_MASK    = 16'hE000,
    parameter logic [DATA_W-1:0]   FILL_VALUE     = 8'h00,
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_valid,
    input  logic                cpu_rw,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                rdata_valid,
    output logic                hit,
    output logic                busy
);

    localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // State the sequencer enters out of reset.
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    localparam logic   RESET_BUSY  = CLEAR_ON_RESET ? 1'b1 : 1'b0;

    // Window decode: only the bits selected by DECODE_MASK take part.
    function automatic logic decode_hit(input logic [ADDR_W-1:0] addr);
        return (addr & DECODE_MASK) == (BASE_ADDR & DECODE_MASK);
    endfunction

    state_t                 state_r;
    logic                   busy_r;
    logic [DEPTH_LOG2-1:0]  ptr_r;
    logic [DATA_W-1:0]      cpu_rdata_r;
    logic                   rdata_valid_r;

    logic [DATA_W-1:0]      mem_r [DEPTH];

    logic                   hit_s;
    logic [DEPTH_LOG2-1:0]  index_s;
    logic                   mem_we_s;
    logic [DEPTH_LOG2-1:0]  mem_waddr_s;
    logic [DATA_W-1:0]      mem_wdata_s;

    // Upper address bits are dropped here; that is what produces the mirrors.
    assign index_s = cpu_addr[DEPTH_LOG2-1:0];
    assign hit_s   = decode_hit(cpu_addr);

    assign hit         = hit_s;
    assign busy        = busy_r;
    assign cpu_rdata   = cpu_rdata_r;
    assign rdata_valid = rdata_valid_r;

    // Single array write port shared by the clear sequencer and CPU writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = PTR_ZERO;
        mem_wdata_s = {DATA_W{1'b0}};
        if (reset) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = ptr_r;
                    mem_wdata_s = FILL_VALUE;
                end
                ST_READY: begin
                    if (cpu_valid && !cpu_rw && hit_s) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = index_s;
                        mem_wdata_s = cpu_wdata;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Clear sequencer, registered read and open-bus latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= RESET_STATE;
            busy_r        <= RESET_BUSY;
            ptr_r         <= PTR_ZERO;
            cpu_rdata_r   <= {DATA_W{1'b0}};
            rdata_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    // CPU traffic is ignored while the fill runs.
                    rdata_valid_r <= 1'b0;
                    ptr_r         <= ptr_r + PTR_ONE;
                    if (ptr_r == PTR_LAST) begin
                        state_r <= ST_READY;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                ST_READY: begin
                    busy_r        <= 1'b0;
                    rdata_valid_r <= 1'b0;
                    if (cpu_valid) begin
                        if (cpu_rw) begin
                            // Read miss leaves the open-bus value alone.
                            if (hit_s) begin
                                cpu_rdata_r   <= mem_r[index_s];
                                rdata_valid_r <= 1'b1;
                            end
                        end else begin
                            // Any write, hit or miss, is the last bus byte.
                            cpu_rdata_r <= cpu_wdata;
                        end
                    end
                end
                default: begin
                    // Unreachable encoding: recover by re-running the fill.
                    state_r       <= ST_CLEAR;
                    busy_r        <= 1'b1;
                    ptr_r         <= PTR_ZERO;
                    rdata_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
